// File: rtl/kamus_pkg.sv
// Shared types for the kamus pipeline: write-back source select, load width/sign
// encoding and the write-back stage FSM states.
package kamus_pkg;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'd0,
    MEM_RESULT = 2'd1,
    PC4_RESULT = 2'd2,
    CSR_RESULT = 2'd3
  } wb_options_e;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    WB_EMPTY    = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_READY    = 2'd2,
    WB_DRAIN    = 2'd3
  } wb_state_e;

endpackage

// File: rtl/kamus_wb_stage_if.sv
// MEM/WB boundary bundle: MEM-stage request, L1D response, flush and the
// register-file write port of the write-back stage.
interface kamus_wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int INSTRET_W = 64
);
  import kamus_pkg::*;

  logic                 mem_valid_i;
  logic                 mem_ready_o;
  logic                 regfile_wr_en_i;
  logic [REG_AW-1:0]    rd_addr_i;
  wb_options_e          wb_sel_i;
  load_type_e           load_type_i;
  logic [1:0]           addr_lsb_i;
  logic [XLEN-1:0]      alu_result_i;
  logic [XLEN-1:0]      pc_plus4_i;
  logic [XLEN-1:0]      csr_rdata_i;
  logic                 l1d_rsp_valid_i;
  logic [XLEN-1:0]      l1d_rsp_data_i;
  logic                 flush_i;
  logic                 regfile_wr_en_o;
  logic [REG_AW-1:0]    rd_addr_o;
  logic [XLEN-1:0]      wb_data_o;
  logic [INSTRET_W-1:0] instret_o;

  modport master (
    output mem_valid_i, regfile_wr_en_i, rd_addr_i, wb_sel_i, load_type_i,
           addr_lsb_i, alu_result_i, pc_plus4_i, csr_rdata_i,
           l1d_rsp_valid_i, l1d_rsp_data_i, flush_i,
    input  mem_ready_o, regfile_wr_en_o, rd_addr_o, wb_data_o, instret_o
  );

  modport slave (
    input  mem_valid_i, regfile_wr_en_i, rd_addr_i, wb_sel_i, load_type_i,
           addr_lsb_i, alu_result_i, pc_plus4_i, csr_rdata_i,
           l1d_rsp_valid_i, l1d_rsp_data_i, flush_i,
    output mem_ready_o, regfile_wr_en_o, rd_addr_o, wb_data_o, instret_o
  );

endinterface

// File: rtl/kamus_load_align.sv
// Sub-word load alignment: picks the addressed byte/halfword out of the L1D
// word and sign- or zero-extends it.
module kamus_load_align
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  load_type_e      load_type,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select from the low address bits; halfwords only use bit 1.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lsb)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lsb[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by load type; unknown encodings pass the word through.
  always_comb begin
    data = rdata;
    case (load_type)
      LB:      data = {{(XLEN-8){byte_s[7]}}, byte_s};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_s};
      LH:      data = {{(XLEN-16){half_s[15]}}, half_s};
      LHU:     data = {{(XLEN-16){1'b0}}, half_s};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/kamus_wb_stage.sv
// Write-back stage: MEM/WB entry register, load-response wait/drain FSM,
// register-file write port and retired-instruction counter.
module kamus_wb_stage
  import kamus_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int INSTRET_W = 64
) (
  input logic             clk_i,
  input logic             rst_ni,
  kamus_wb_stage_if.slave bus
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  wb_state_e            state_r;
  logic                 wr_en_r;
  logic [REG_AW-1:0]    rd_r;
  load_type_e           load_type_r;
  logic [1:0]           addr_lsb_r;
  logic [XLEN-1:0]      data_r;
  logic                 rf_we_r;
  logic                 ready_r;
  logic [INSTRET_W-1:0] instret_r;

  logic                 accept_s;
  logic [XLEN-1:0]      sel_data_s;
  logic [XLEN-1:0]      aligned_s;

  assign accept_s = bus.mem_valid_i & ready_r & ~bus.flush_i;

  // Result source for non-load instructions; a load's data arrives later.
  always_comb begin
    sel_data_s = {XLEN{1'b0}};
    case (bus.wb_sel_i)
      ALU_RESULT: sel_data_s = bus.alu_result_i;
      MEM_RESULT: sel_data_s = {XLEN{1'b0}};
      PC4_RESULT: sel_data_s = bus.pc_plus4_i;
      CSR_RESULT: sel_data_s = bus.csr_rdata_i;
      default:    sel_data_s = {XLEN{1'b0}};
    endcase
  end

  kamus_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .load_type (load_type_r),
    .addr_lsb  (addr_lsb_r),
    .rdata     (bus.l1d_rsp_data_i),
    .data      (aligned_s)
  );

  // FSM, entry register and commit outputs. The write strobe and counter are
  // set on the edge that enters WB_READY, so they are visible in the commit cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= WB_EMPTY;
      wr_en_r     <= 1'b0;
      rd_r        <= {REG_AW{1'b0}};
      load_type_r <= LB;
      addr_lsb_r  <= 2'd0;
      data_r      <= {XLEN{1'b0}};
      rf_we_r     <= 1'b0;
      ready_r     <= 1'b1;
      instret_r   <= {INSTRET_W{1'b0}};
    end else begin
      rf_we_r <= 1'b0;
      case (state_r)
        WB_EMPTY, WB_READY: begin
          if (accept_s) begin
            wr_en_r     <= bus.regfile_wr_en_i;
            rd_r        <= bus.rd_addr_i;
            load_type_r <= bus.load_type_i;
            addr_lsb_r  <= bus.addr_lsb_i;
            data_r      <= sel_data_s;
            if (bus.wb_sel_i == MEM_RESULT) begin
              state_r <= WB_WAIT_MEM;
              ready_r <= 1'b0;
            end else begin
              state_r   <= WB_READY;
              ready_r   <= 1'b1;
              rf_we_r   <= bus.regfile_wr_en_i & (|bus.rd_addr_i);
              instret_r <= instret_r + INSTRET_ONE;
            end
          end else begin
            state_r <= WB_EMPTY;
            ready_r <= 1'b1;
          end
        end
        WB_WAIT_MEM: begin
          if (bus.flush_i) begin
            wr_en_r <= 1'b0;
            if (bus.l1d_rsp_valid_i) begin
              state_r <= WB_EMPTY;
              ready_r <= 1'b1;
            end else begin
              state_r <= WB_DRAIN;
              ready_r <= 1'b0;
            end
          end else if (bus.l1d_rsp_valid_i) begin
            data_r    <= aligned_s;
            state_r   <= WB_READY;
            ready_r   <= 1'b1;
            rf_we_r   <= wr_en_r & (|rd_r);
            instret_r <= instret_r + INSTRET_ONE;
          end else begin
            state_r <= WB_WAIT_MEM;
            ready_r <= 1'b0;
          end
        end
        WB_DRAIN: begin
          if (bus.l1d_rsp_valid_i) begin
            state_r <= WB_EMPTY;
            ready_r <= 1'b1;
          end else begin
            state_r <= WB_DRAIN;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= WB_EMPTY;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_ready_o     = ready_r;
  assign bus.regfile_wr_en_o = rf_we_r;
  assign bus.rd_addr_o       = rd_r;
  assign bus.wb_data_o       = data_r;
  assign bus.instret_o       = instret_r;

endmodule

// File: tb/tb_kamus_wb_stage.sv
// Directed bench for kamus_wb_stage: an event-level model predicts every cycle,
// and literal expectations pin the key scenarios.
module tb_kamus_wb_stage;
  import kamus_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   notes  = 0;

  kamus_wb_stage_if #(.XLEN(32), .REG_AW(5), .INSTRET_W(64)) bus ();

  kamus_wb_stage #(.XLEN(32), .REG_AW(5), .INSTRET_W(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level alignment: shift the word down by the byte offset and extend.
  function automatic logic [31:0] m_align(input int lt, input int lsb, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lsb)) & 32'h0000_00FF;
    h = (w >> (16 * (lsb / 2))) & 32'h0000_FFFF;
    case (lt)
      0:       return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      4:       return b;
      1:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      5:       return h;
      default: return w;
    endcase
  endfunction

  // Model: a pending load, a drain owed to a flushed load, and the commit
  // (if any) that is visible during the current cycle.
  logic        m_load, m_drain, m_commit, m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_cnt;
  logic        p_wr;
  logic [4:0]  p_rd;
  int          p_lt, p_lsb;
  logic        m_acc;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_load = 1'b0; m_drain = 1'b0; m_commit = 1'b0; m_wr = 1'b0;
        m_rd = 5'd0; m_data = 32'd0; m_cnt = 64'd0;
      end else begin
        m_acc    = bus.mem_valid_i && !m_load && !m_drain && !bus.flush_i;
        m_commit = 1'b0;
        if (m_load) begin
          if (bus.flush_i) begin
            m_load  = 1'b0;
            m_drain = !bus.l1d_rsp_valid_i;
          end else if (bus.l1d_rsp_valid_i) begin
            m_load = 1'b0; m_commit = 1'b1; m_wr = p_wr; m_rd = p_rd;
            m_data = m_align(p_lt, p_lsb, bus.l1d_rsp_data_i);
            m_cnt  = m_cnt + 64'd1;
          end
        end else if (m_drain) begin
          if (bus.l1d_rsp_valid_i) m_drain = 1'b0;
        end else begin
          if (bus.l1d_rsp_valid_i) begin
            notes++;
            $display("note: protocol error, L1D response with no load outstanding at %0t", $time);
          end
          if (m_acc) begin
            if (bus.wb_sel_i == MEM_RESULT) begin
              m_load = 1'b1; p_wr = bus.regfile_wr_en_i; p_rd = bus.rd_addr_i;
              p_lt = int'(bus.load_type_i); p_lsb = int'(bus.addr_lsb_i);
            end else begin
              m_commit = 1'b1; m_wr = bus.regfile_wr_en_i; m_rd = bus.rd_addr_i;
              m_data = (bus.wb_sel_i == ALU_RESULT) ? bus.alu_result_i :
                       (bus.wb_sel_i == PC4_RESULT) ? bus.pc_plus4_i : bus.csr_rdata_i;
              m_cnt  = m_cnt + 64'd1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    logic exp_we;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_we = m_commit && m_wr && (m_rd != 5'd0);
        chk("cyc_wr_en", 64'(bus.regfile_wr_en_o), 64'(exp_we));
        chk("cyc_ready", 64'(bus.mem_ready_o), 64'(!(m_load || m_drain)));
        chk("cyc_instret", bus.instret_o, m_cnt);
        if (exp_we) begin
          chk("cyc_rd", 64'(bus.rd_addr_o), 64'(m_rd));
          chk("cyc_data", 64'(bus.wb_data_o), 64'(m_data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.mem_valid_i = 1'b0; bus.l1d_rsp_valid_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic issue(input wb_options_e sel, input load_type_e lt, input logic [1:0] lsb,
                       input logic wr, input logic [4:0] rd, input logic [31:0] val);
    bus.mem_valid_i = 1'b1; bus.regfile_wr_en_i = wr; bus.rd_addr_i = rd;
    bus.wb_sel_i = sel; bus.load_type_i = lt; bus.addr_lsb_i = lsb;
    bus.alu_result_i = ~val; bus.pc_plus4_i = ~val; bus.csr_rdata_i = ~val;
    case (sel)
      ALU_RESULT: bus.alu_result_i = val;
      PC4_RESULT: bus.pc_plus4_i   = val;
      CSR_RESULT: bus.csr_rdata_i  = val;
      default:    bus.alu_result_i = ~val;
    endcase
  endtask

  task automatic respond(input logic [31:0] w);
    bus.mem_valid_i = 1'b0; bus.l1d_rsp_valid_i = 1'b1; bus.l1d_rsp_data_i = w;
  endtask

  load_type_e  t_lt [5] = '{LH, LBU, LW, LB, LH};
  logic [1:0]  t_lsb[5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
  logic [31:0] t_w  [5] = '{32'h1234_8001, 32'h0000_A500, 32'hDEAD_BEEF, 32'h0000_007F, 32'h7FFF_1234};
  logic [31:0] t_exp[5] = '{32'hFFFF_8001, 32'h0000_00A5, 32'hDEAD_BEEF, 32'h0000_007F, 32'h0000_7FFF};

  initial begin : stim
    logic [63:0] base;
    rst_n = 1'b0;
    idle();
    issue(ALU_RESULT, LW, 2'd0, 1'b0, 5'd0, 32'd0);
    bus.mem_valid_i = 1'b0; bus.l1d_rsp_data_i = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("rst_rd", 64'(bus.rd_addr_o), 64'd0);
    chk("rst_data", 64'(bus.wb_data_o), 64'd0);
    chk("rst_instret", bus.instret_o, 64'd0);
    chk("rst_ready", 64'(bus.mem_ready_o), 64'd1);
    rst_n = 1'b1;
    tick();

    // ALU commit
    issue(ALU_RESULT, LW, 2'd0, 1'b1, 5'd5, 32'h0000_1234);
    tick(); idle();
    chk("alu_wr_en", 64'(bus.regfile_wr_en_o), 64'd1);
    chk("alu_rd", 64'(bus.rd_addr_o), 64'd5);
    chk("alu_data", 64'(bus.wb_data_o), 64'h1234);
    chk("alu_instret", bus.instret_o, 64'd1);
    tick();

    // LB at byte 3, response three cycles after acceptance
    issue(MEM_RESULT, LB, 2'd3, 1'b1, 5'd7, 32'd0);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      chk("lb_wait_ready", 64'(bus.mem_ready_o), 64'd0);
      tick();
    end
    chk("lb_wait_ready", 64'(bus.mem_ready_o), 64'd0);
    respond(32'h80FF_FF7F);
    tick(); idle();
    chk("lb_wr_en", 64'(bus.regfile_wr_en_o), 64'd1);
    chk("lb_data", 64'(bus.wb_data_o), 64'hFFFF_FF80);
    chk("lb_instret", bus.instret_o, 64'd2);
    tick();

    // LHU upper halfword
    issue(MEM_RESULT, LHU, 2'd2, 1'b1, 5'd9, 32'd0);
    tick();
    respond(32'hBEEF_0000);
    tick(); idle();
    chk("lhu_data", 64'(bus.wb_data_o), 64'h0000_BEEF);
    chk("lhu_rd", 64'(bus.rd_addr_o), 64'd9);

    // Remaining load shapes, issued back-to-back from the commit cycle
    for (int i = 0; i < 5; i++) begin
      issue(MEM_RESULT, t_lt[i], t_lsb[i], 1'b1, 5'(12 + i), 32'd0);
      tick();
      respond(t_w[i]);
      tick(); idle();
      chk("load_tbl_data", 64'(bus.wb_data_o), 64'(t_exp[i]));
    end
    tick();

    // Four back-to-back commits, the last to x0
    base = bus.instret_o;
    issue(PC4_RESULT, LW, 2'd0, 1'b1, 5'd1, 32'h0000_0100); tick();
    chk("b2b_pc4", 64'(bus.wb_data_o), 64'h100);
    issue(CSR_RESULT, LW, 2'd0, 1'b1, 5'd2, 32'h0000_CAFE); tick();
    chk("b2b_csr", 64'(bus.wb_data_o), 64'hCAFE);
    issue(ALU_RESULT, LW, 2'd0, 1'b1, 5'd3, 32'h0000_0077); tick();
    chk("b2b_alu", 64'(bus.wb_data_o), 64'h77);
    issue(ALU_RESULT, LW, 2'd0, 1'b1, 5'd0, 32'h0000_0055); tick(); idle();
    chk("b2b_x0_wr_en", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("b2b_instret", bus.instret_o, base + 64'd4);
    tick();

    // Flush while waiting, response two cycles later is drained
    base = bus.instret_o;
    issue(MEM_RESULT, LW, 2'd0, 1'b1, 5'd4, 32'd0); tick(); idle();
    bus.flush_i = 1'b1; tick(); idle();
    chk("drain_ready", 64'(bus.mem_ready_o), 64'd0);
    tick();
    respond(32'h1111_2222); tick(); idle();
    chk("drain_ready_back", 64'(bus.mem_ready_o), 64'd1);
    chk("drain_wr_en", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("drain_instret", bus.instret_o, base);

    // Flush and response in the same cycle
    issue(MEM_RESULT, LW, 2'd0, 1'b1, 5'd4, 32'd0); tick(); idle();
    respond(32'h3333_4444); bus.flush_i = 1'b1; tick(); idle();
    chk("flushrsp_ready", 64'(bus.mem_ready_o), 64'd1);
    chk("flushrsp_instret", bus.instret_o, base);

    // Flush in the commit cycle keeps the commit but blocks the new accept
    issue(ALU_RESULT, LW, 2'd0, 1'b1, 5'd10, 32'h0000_00AA); tick();
    chk("rdyflush_commit", 64'(bus.wb_data_o), 64'hAA);
    issue(ALU_RESULT, LW, 2'd0, 1'b1, 5'd11, 32'h0000_00BB); bus.flush_i = 1'b1;
    tick(); idle();
    chk("rdyflush_no_accept", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("rdyflush_instret", bus.instret_o, base + 64'd1);

    // Asynchronous reset with a load outstanding; the late response is ignored
    issue(MEM_RESULT, LB, 2'd0, 1'b1, 5'd6, 32'd0); tick(); idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.mem_ready_o), 64'd1);
    chk("arst_instret", bus.instret_o, 64'd0);
    chk("arst_wr_en", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("arst_data", 64'(bus.wb_data_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    respond(32'h0000_00FF); tick(); idle();
    chk("post_rst_wr_en", 64'(bus.regfile_wr_en_o), 64'd0);
    chk("post_rst_instret", bus.instret_o, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kamus_wb_stage.md
# kamus_wb_stage

Registered write-back stage with a MEM/WB pipeline register, valid/ready handshake and a multi-cycle L1D load-response path. It sits between the MEM stage and the register file, after the L1D. It selects among four result sources, aligns and sign-extends sub-word loads, suppresses writes to x0, supports pipeline flush, and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.
- `REG_AW`, 5: register-address width.
- `INSTRET_W`, 64: width of the retire counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `mem_valid_i`, in, 1: MEM stage presents an instruction.
- `mem_ready_o`, out, 1: stage can accept an instruction this cycle.
- `regfile_wr_en_i`, in, 1: instruction writes rd.
- `rd_addr_i`, in, REG_AW: destination register.
- `wb_sel_i`, in, 2: result source, `wb_options_e`.
- `load_type_i`, in, 3: load width and sign, `load_type_e`.
- `addr_lsb_i`, in, 2: load address bits [1:0].
- `alu_result_i`, in, XLEN: ALU result.
- `pc_plus4_i`, in, XLEN: link value.
- `csr_rdata_i`, in, XLEN: CSR read data.
- `l1d_rsp_valid_i`, in, 1: L1D read data valid.
- `l1d_rsp_data_i`, in, XLEN: L1D read word.
- `flush_i`, in, 1: squash the not-yet-committed entry.
- `regfile_wr_en_o`, out, 1: register-file write strobe.
- `rd_addr_o`, out, REG_AW: write address.
- `wb_data_o`, out, XLEN: write data.
- `instret_o`, out, INSTRET_W: count of retired instructions.

## Operation
- FSM states are `WB_EMPTY`, `WB_WAIT_MEM`, `WB_READY` and `WB_DRAIN`. Reset state is `WB_EMPTY`.
- An instruction is accepted on `mem_valid_i & mem_ready_o & ~flush_i`. On acceptance, all `_i` fields are captured into the entry register.
- `mem_ready_o` is 1 in `WB_EMPTY` and `WB_READY`, and 0 in `WB_WAIT_MEM` and `WB_DRAIN`.
- Accepting an instruction with `wb_sel==MEM_RESULT` moves the FSM to `WB_WAIT_MEM`. Accepting any other source moves it to `WB_READY`.
- In `WB_WAIT_MEM`, `l1d_rsp_valid_i` causes the aligned load data to be captured into the entry, and the FSM moves to `WB_READY`.
- In `WB_READY`, the entry commits:
  - `regfile_wr_en_o = entry.wr_en & (entry.rd != 0)`.
  - `instret_o` increments by 1 on every commit, including rd=0 and non-writing instructions.
- `WB_READY` with a new acceptance in the same cycle goes to `WB_WAIT_MEM` or `WB_READY` according to the new instruction's source, giving back-to-back throughput of 1 per cycle. `WB_READY` with no acceptance goes to `WB_EMPTY`.
- Flush behaviour:
  - In `WB_READY`, `flush_i` does not cancel the commit, because that entry is older than the flush. The flush does block acceptance that cycle, and the FSM goes to `WB_EMPTY`.
  - In `WB_WAIT_MEM`, `flush_i` discards the entry and moves to `WB_DRAIN`. If `l1d_rsp_valid_i` is 1 in that same cycle, the response is dropped and the FSM goes to `WB_EMPTY` instead.
  - In `WB_DRAIN`, the next `l1d_rsp_valid_i` is consumed without a write, and the FSM goes to `WB_EMPTY`. `flush_i` in `WB_DRAIN` or `WB_EMPTY` has no effect.
- `l1d_rsp_valid_i` in `WB_EMPTY` or `WB_READY` is ignored. The bench flags it as a protocol error.
- Load alignment, where b = byte `addr_lsb` and h = halfword `addr_lsb[1]`:
  - LB: sign-extend b.
  - LBU: zero-extend b.
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: the full word. `addr_lsb` is ignored.
  - Misalignment is not detected here; it is handled in MEM.
- Data mux: ALU_RESULT, MEM_RESULT (the aligned captured data), PC4_RESULT and CSR_RESULT.
- `instret_o` wraps modulo 2^INSTRET_W.

## Timing
- Reset values: FSM `WB_EMPTY`, entry cleared, `regfile_wr_en_o=0`, `rd_addr_o=0`, `wb_data_o=0`, `instret_o=0`, `mem_ready_o=1`.
- `rd_addr_o` and `wb_data_o` are driven from the entry register in every state. They are meaningful only while `regfile_wr_en_o` is 1.
- Non-load latency: accepted at edge N, commits in the cycle after edge N, i.e. it is visible to the register file at edge N+1.
- Load latency: accepted at N, response seen at cycle R ≥ N+1, commits in cycle R+1. A response is never used in its acceptance cycle.
- Reset mid-operation returns immediately to the reset values. An outstanding L1D response after reset is ignored.

## Structure
- `kamus_pkg` is extended with:
  - `wb_options_e` gains `PC4_RESULT=2'd2` and `CSR_RESULT=2'd3`, in addition to ALU_RESULT=0 and MEM_RESULT=1.
  - `load_type_e`: LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - `wb_state_e`.
- Sub-module `kamus_load_align` is purely combinational, with `load_type`, `addr_lsb` and `rdata` in and `XLEN` data out.
- The entry register, FSM and counter stay in `kamus_wb_stage`.

## Test plan
- ALU commit: accept ALU_RESULT with rd=5, alu=0x1234 → next cycle `regfile_wr_en_o=1`, `rd_addr_o=5`, `wb_data_o=0x1234`, `instret_o=1`.
- Sign-extending byte load: accept LB with addr_lsb=3, then after 3 cycles rsp 0x80FF_FF7F → the following cycle `wb_data_o=0xFFFF_FF80`, and `mem_ready_o` stays 0 while waiting.
- Unsigned halfword load: accept LHU with addr_lsb=2 and rsp 0xBEEF_0000 → `wb_data_o=0x0000_BEEF`.
- Back-to-back commits: 4 consecutive accepts of PC4, CSR, ALU and a rd=0 ALU instruction → 4 consecutive commit cycles, the fourth with `regfile_wr_en_o=0`, and `instret_o` advances 0→4.
- Flush during a load: flush in `WB_WAIT_MEM`, then rsp 2 cycles later → no write, `instret_o` unchanged, `mem_ready_o` returns to 1 the cycle after the response.
- Reset with a load pending: assert `rst_ni=0` with a load pending → all outputs at reset values asynchronously, and the later rsp is ignored.
